// File: rtl/axi_light_pkg.sv
// Shared AXI-light definitions: response encodings, bus widths and the
// master bridge state type.
package axi_light_pkg;

  localparam int AXI_ADDR_WIDTH  = 32;
  localparam int AXI_DATA_WIDTH  = 32;
  localparam int AXI_WSTRB_WIDTH = AXI_DATA_WIDTH / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ADDR_DATA,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_DONE
  } bridge_state_e;

endpackage

// File: rtl/if_axi_light.sv
// AXI-light bus bundle (five channels, no bursts) with master and slave views.
interface if_axi_light
  import axi_light_pkg::*;
#(
  parameter int ADDR_WIDTH = AXI_ADDR_WIDTH,
  parameter int DATA_WIDTH = AXI_DATA_WIDTH
);

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;

  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;

  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/axi_light_master_bridge.sv
// Turns a hold-until-done memory request into one AXI-light read or write,
// one transaction outstanding at a time.
//
//   state           | meaning
//   ----------------+-----------------------------------------------------
//   ST_IDLE         | latch request inputs, launch write (priority) or read
//   ST_WR_ADDR_DATA | AW and W offered together, each retired independently
//   ST_WR_RESP      | BREADY high, waiting for the write response
//   ST_RD_ADDR      | ARVALID high, waiting for ARREADY
//   ST_RD_DATA      | RREADY high, waiting for read data
//   ST_DONE         | mem_done pulse; requests ignored this cycle
module axi_light_master_bridge
  import axi_light_pkg::*;
#(
  parameter int         ADDR_WIDTH = AXI_ADDR_WIDTH,
  parameter int         DATA_WIDTH = AXI_DATA_WIDTH,
  parameter logic [2:0] PROT       = 3'b000
) (
  input  logic                    clk,
  input  logic                    res_n,
  if_axi_light.master             m_axi,
  input  logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic                    mem_read,
  input  logic                    mem_write,
  output logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    mem_done,
  output logic                    mem_err
);

  bridge_state_e           state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;
  logic                    awvalid_q;
  logic                    wvalid_q;
  logic                    bready_q;
  logic                    arvalid_q;
  logic                    rready_q;
  logic                    aw_done;
  logic                    w_done;
  logic                    aw_hs;
  logic                    w_hs;

  assign aw_hs = awvalid_q & m_axi.awready;
  assign w_hs  = wvalid_q & m_axi.wready;

  assign m_axi.awaddr  = addr_q;
  assign m_axi.awprot  = PROT;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.araddr  = addr_q;
  assign m_axi.arprot  = PROT;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state     <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      mem_rdata <= '0;
      mem_done  <= 1'b0;
      mem_err   <= 1'b0;
    end else begin
      mem_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          addr_q  <= mem_addr;
          wdata_q <= mem_wdata;
          wstrb_q <= mem_wstrb;
          if (mem_write) begin
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            state     <= ST_WR_ADDR_DATA;
          end else if (mem_read) begin
            arvalid_q <= 1'b1;
            state     <= ST_RD_ADDR;
          end
        end
        ST_WR_ADDR_DATA: begin
          // AW and W retire independently; the flags remember which is gone
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done   <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            bready_q <= 1'b1;
            state    <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (m_axi.bvalid) begin
            bready_q <= 1'b0;
            mem_err  <= (m_axi.bresp != RESP_OKAY);
            mem_done <= 1'b1;
            state    <= ST_DONE;
          end
        end
        ST_RD_ADDR: begin
          if (m_axi.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (m_axi.rvalid) begin
            rready_q  <= 1'b0;
            mem_rdata <= m_axi.rdata;
            mem_err   <= (m_axi.rresp != RESP_OKAY);
            mem_done  <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
